// File: rtl/mc_run_capture.sv
// mc_run_capture: run controller that pulses START, captures core write-strobe falling edges into a FWFT FIFO, and waits for all END or timeout.
// Ports: clk/RESET (async, active high); go starts a run; core_end/core_dwrite/core_wdata per-core inputs;
//   start_out/busy/done/timed_out/overflow status; rd_en/rd_data/rd_core/empty/level FIFO read side.
// Optional: define CAPTURE_STAMP_EN to add rd_stamp, the RUN cycle at which each entry's edge was seen.
module mc_run_capture #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 64,
  parameter int TIMEOUT   = 100000,
  parameter int START_LEN = 1,
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        RESET,
  input  logic                        go,
  input  logic [NUM_CORES-1:0]        core_end,
  input  logic [NUM_CORES-1:0]        core_dwrite,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  output logic                        start_out,
  output logic                        busy,
  output logic                        done,
  output logic                        timed_out,
  output logic                        overflow,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           rd_data,
  output logic [CW-1:0]               rd_core,
`ifdef CAPTURE_STAMP_EN
  output logic [31:0]                 rd_stamp,
`endif
  output logic                        empty,
  output logic [AW:0]                 level
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_DONE, S_TOUT} state_t;
  state_t r_state, w_next;
  logic [31:0] r_scnt, r_cyc;
  logic [NUM_CORES-1:0] r_dw_q, r_pend, r_endl, w_fall, w_sel, w_psel;
  logic [NUM_CORES*DATA_W-1:0] r_wd_q;
  logic [DATA_W-1:0] r_pdata [NUM_CORES];
  logic [DATA_W-1:0] r_mem_d [DEPTH];
  logic [CW-1:0] r_mem_c [DEPTH];
  logic [CW-1:0] w_sel_idx;
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic r_ovf, w_clr, w_run, w_full, w_pop, w_push, w_tout, w_fin;
`ifdef CAPTURE_STAMP_EN
  logic [31:0] r_pstamp [NUM_CORES];
  logic [31:0] r_mem_s [DEPTH];
  assign rd_stamp = empty ? '0 : r_mem_s[r_rp];
`endif
  assign w_clr = go & (r_state == S_IDLE || r_state == S_DONE || r_state == S_TOUT);
  assign w_run = r_state == S_RUN;
  assign w_fall = w_run ? (r_dw_q & ~core_dwrite) : '0;
  assign empty = r_cnt == '0;
  assign w_full = r_cnt == (AW+1)'(DEPTH);
  assign w_pop = rd_en & ~empty & ~w_clr;
  // A full FIFO still accepts a push when a pop frees the head slot in the same cycle
  assign w_push = w_run & (|r_pend) & (~w_full | w_pop);
  // Lowest-index pending core wins the single push slot
  assign w_sel = r_pend & (~r_pend + 1'b1);
  assign w_psel = w_push ? w_sel : '0;
  assign w_tout = (TIMEOUT != 0) && (r_cyc == 32'(TIMEOUT - 1));
  // A fall in the same cycle would create new pending work, so it blocks completion
  assign w_fin = (&r_endl) & ~(|r_pend) & ~(|w_fall);
  assign start_out = r_state == S_START;
  assign busy = r_state == S_START || w_run;
  assign done = r_state == S_DONE;
  assign timed_out = r_state == S_TOUT;
  assign overflow = r_ovf;
  assign level = r_cnt;
  assign rd_data = empty ? '0 : r_mem_d[r_rp];
  assign rd_core = empty ? '0 : r_mem_c[r_rp];
  always_comb begin
    w_sel_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) w_sel_idx = r_pend[i] ? CW'(i) : w_sel_idx;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_TOUT: w_next = go ? S_START : r_state;
      S_START: w_next = (r_scnt == 32'(START_LEN - 1)) ? S_RUN : S_START;
      S_RUN: w_next = w_fin ? S_DONE : (w_tout ? S_TOUT : S_RUN);
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_scnt <= '0;
      r_cyc <= '0;
      r_dw_q <= '0;
      r_pend <= '0;
      r_endl <= '0;
      r_ovf <= 1'b0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_dw_q <= core_dwrite;
      if (w_clr) begin
        r_scnt <= '0;
        r_cyc <= '0;
        r_pend <= '0;
        r_endl <= '0;
        r_ovf <= 1'b0;
        r_wp <= '0;
        r_rp <= '0;
        r_cnt <= '0;
      end else begin
        r_scnt <= start_out ? r_scnt + 1 : r_scnt;
        r_cyc <= (w_run && r_cyc != '1) ? r_cyc + 1 : r_cyc;
        r_endl <= busy ? (r_endl | core_end) : r_endl;
        r_wp <= r_wp + AW'(w_push);
        r_rp <= r_rp + AW'(w_pop);
        r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        if (w_run && w_next == S_TOUT) begin
          // Anything still pending (or just detected) at abort is lost
          r_pend <= '0;
          r_ovf <= r_ovf | (|(r_pend & ~w_psel)) | (|w_fall);
        end else begin
          r_pend <= (r_pend & ~w_psel) | w_fall;
          r_ovf <= r_ovf | (|(w_fall & r_pend & ~w_psel));
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    r_wd_q <= core_wdata;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (w_fall[k]) r_pdata[k] <= r_wd_q[k*DATA_W +: DATA_W];
`ifdef CAPTURE_STAMP_EN
      if (w_fall[k]) r_pstamp[k] <= r_cyc;
`endif
    end
    if (w_push) begin
      r_mem_d[r_wp] <= r_pdata[w_sel_idx];
      r_mem_c[r_wp] <= w_sel_idx;
`ifdef CAPTURE_STAMP_EN
      r_mem_s[r_wp] <= r_pstamp[w_sel_idx];
`endif
    end
  end
endmodule

// File: tb/tb_mc_run_capture.sv
// tb_mc_run_capture: directed scoreboard bench for mc_run_capture with DEPTH=4, TIMEOUT=50, START_LEN=3.
module tb_mc_run_capture;
  logic clk = 1'b0;
  logic RESET = 1'b1;
  logic go = 1'b0;
  logic rd_en = 1'b0;
  logic [3:0] core_end = '0;
  logic [3:0] core_dwrite = '0;
  logic [63:0] core_wdata = '0;
  logic start_out, busy, done, timed_out, overflow, empty;
  logic [15:0] rd_data;
  logic [1:0] rd_core;
  logic [2:0] level;
`ifdef CAPTURE_STAMP_EN
  logic [31:0] rd_stamp;
`endif
  int n_run = 0;
  int n_fail = 0;
  int n_so;
  logic [17:0] exp_q [$];
  logic [17:0] mon_e;
  always #5 clk = ~clk;
  mc_run_capture #(.NUM_CORES(4), .DATA_W(16), .DEPTH(4), .TIMEOUT(50), .START_LEN(3)) dut (
    .clk(clk), .RESET(RESET), .go(go), .core_end(core_end), .core_dwrite(core_dwrite),
    .core_wdata(core_wdata), .start_out(start_out), .busy(busy), .done(done),
    .timed_out(timed_out), .overflow(overflow), .rd_en(rd_en), .rd_data(rd_data),
    .rd_core(rd_core),
`ifdef CAPTURE_STAMP_EN
    .rd_stamp(rd_stamp),
`endif
    .empty(empty), .level(level)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int k, input logic [15:0] d, input bit sb);
    core_dwrite[k] = 1'b1;
    core_wdata[k*16 +: 16] = d;
    if (sb) exp_q.push_back({2'(k), d});
    tick();
    core_dwrite[k] = 1'b0;
    tick();
  endtask
  task automatic start_run();
    core_end = '0;
    exp_q.delete();
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (3) tick();
  endtask
  task automatic pop(input int n);
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!RESET && rd_en && !empty) begin
      if (exp_q.size() == 0) begin
        n_run++;
        n_fail++;
        $display("FAIL pop_unexpected: got core %0d data %0h expected no entry", rd_core, rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_core", 32'(rd_core), 32'(mon_e[17:16]));
        chk("pop_data", 32'(rd_data), 32'(mon_e[15:0]));
      end
    end
  end
  initial begin
    repeat (2) tick();
    chk("rst_start", 32'(start_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_tout", 32'(timed_out), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_rdata", 32'(rd_data), 0);
    chk("rst_rcore", 32'(rd_core), 0);
    RESET = 1'b0;
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("busy_first_start", 32'(busy), 1);
    n_so = 0;
    repeat (6) begin
      n_so += int'(start_out);
      tick();
    end
    chk("start_len", 32'(n_so), 3);
    chk("run_busy", 32'(busy), 1);
    wr(2, 16'h00A5, 1'b1);
    tick();
    chk("single_level", 32'(level), 1);
    chk("single_empty", 32'(empty), 0);
    pop(1);
    chk("single_popped_empty", 32'(empty), 1);
    core_dwrite = 4'b1001;
    core_wdata[15:0] = 16'h1111;
    core_wdata[63:48] = 16'h3333;
    exp_q.push_back({2'd0, 16'h1111});
    exp_q.push_back({2'd3, 16'h3333});
    tick();
    core_dwrite = '0;
    repeat (3) tick();
    chk("dual_level", 32'(level), 2);
    pop(2);
    chk("dual_ovf", 32'(overflow), 0);
    chk("dual_empty", 32'(empty), 1);
    core_end = 4'hF;
    repeat (2) tick();
    chk("run1_done", 32'(done), 1);
    chk("run1_busy", 32'(busy), 0);
    start_run();
    for (int i = 0; i < 6; i++) wr(i % 4, 16'h0010 + 16'(i), 1'b1);
    repeat (2) tick();
    chk("full_level", 32'(level), 4);
    chk("full_ovf", 32'(overflow), 0);
    pop(6);
    chk("full_drained_empty", 32'(empty), 1);
    chk("full_drained_level", 32'(level), 0);
    chk("full_ovf_after", 32'(overflow), 0);
    core_end = 4'hF;
    repeat (2) tick();
    chk("run2_done", 32'(done), 1);
    start_run();
    wr(1, 16'h0021, 1'b1);
    wr(2, 16'h0022, 1'b1);
    wr(3, 16'h0023, 1'b1);
    wr(1, 16'h0024, 1'b1);
    wr(0, 16'h0A0A, 1'b1);
    core_end = 4'hF;
    repeat (3) tick();
    chk("end_pending_done", 32'(done), 0);
    chk("end_pending_busy", 32'(busy), 1);
    pop(1);
    tick();
    chk("end_after_push_done", 32'(done), 1);
    pop(4);
    chk("run3_empty", 32'(empty), 1);
    start_run();
    core_end = 4'b1101;
    wr(2, 16'h0042, 1'b0);
    repeat (47) tick();
    chk("tout_before", 32'(timed_out), 0);
    chk("tout_before_busy", 32'(busy), 1);
    tick();
    chk("tout_at_50", 32'(timed_out), 1);
    chk("tout_done", 32'(done), 0);
    chk("tout_busy", 32'(busy), 0);
    chk("tout_level", 32'(level), 1);
    chk("tout_ovf", 32'(overflow), 0);
    start_run();
    chk("restart_empty", 32'(empty), 1);
    chk("restart_level", 32'(level), 0);
    chk("restart_tout", 32'(timed_out), 0);
    wr(1, 16'h0051, 1'b1);
    wr(2, 16'h0052, 1'b1);
    wr(3, 16'h0053, 1'b1);
    wr(1, 16'h0054, 1'b1);
    wr(0, 16'hBEEF, 1'b0);
    chk("replace_ovf_before", 32'(overflow), 0);
    wr(0, 16'hCAFE, 1'b1);
    chk("replace_ovf", 32'(overflow), 1);
    pop(5);
    core_end = 4'hF;
    repeat (2) tick();
    chk("run5_done", 32'(done), 1);
    chk("ovf_sticky", 32'(overflow), 1);
    start_run();
    chk("ovf_cleared", 32'(overflow), 0);
    wr(2, 16'h7777, 1'b0);
    tick();
    chk("pre_reset_level", 32'(level), 1);
    #2 RESET = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_rdata", 32'(rd_data), 0);
    chk("arst_rcore", 32'(rd_core), 0);
    tick();
    RESET = 1'b0;
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("start_before_arst", 32'(start_out), 1);
    #2 RESET = 1'b1;
    #1;
    chk("arst_start_out", 32'(start_out), 0);
    chk("arst_start_busy", 32'(busy), 0);
    tick();
    RESET = 1'b0;
    tick();
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
